// File: rtl/alu_merge_pkg.sv
// -----------------------------------------------------------------------------
// alu_merge_pkg
// Shared definitions for the ALU result merge block.
//   SRC_CH1 / SRC_CH2 : source tags, using the aluOpSel encoding (1 = channel 1,
//                       0 = channel 2). They appear on out_src and in the issue-order
//                       FIFO.
//   grant_e           : round-robin state. It records which channel won last.
//   sel_e             : combinational arbitration result for the current cycle.
//   cnt_width()       : width of an occupancy counter that must hold 0..depth.
// -----------------------------------------------------------------------------
package alu_merge_pkg;

  localparam logic SRC_CH1 = 1'b1;
  localparam logic SRC_CH2 = 1'b0;

  // Encoded so the value matches the source tag of the winning channel.
  typedef enum logic {
    GRANT_CH2 = 1'b0,
    GRANT_CH1 = 1'b1
  } grant_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CH1  = 2'd1,
    SEL_CH2  = 2'd2
  } sel_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/merge_order_fifo.sv
// -----------------------------------------------------------------------------
// merge_order_fifo
// This is a 1-bit-wide issue-order FIFO. Each entry is the aluOpSel value of an
// issued operation. The head tells the merge arbiter which channel's result must
// leave next. The module exists only when MERGE_INORDER_EN is defined.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write push_sel this cycle. It is ignored while full.
//   push_sel   : aluOpSel value to record
//   pop        : drop the head this cycle. It is ignored while empty.
//   head       : oldest entry. It is only meaningful while !empty.
//   empty      : no entries
//   full       : ORDER_DEPTH entries held
// A write is visible at the head one cycle later at the earliest. There is no
// write-to-head bypass.
// -----------------------------------------------------------------------------
`ifdef MERGE_INORDER_EN
module merge_order_fifo
  import alu_merge_pkg::*;
#(
  parameter int ORDER_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_sel,
  input  logic pop,
  output logic head,
  output logic empty,
  output logic full
);

  localparam int CW = cnt_width(ORDER_DEPTH);
  localparam int PW = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;

  logic [ORDER_DEPTH-1:0] mem;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   push_ok;
  logic                   pop_ok;

  // Pointer increment wraps explicitly, so depths that are not a power of two work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(ORDER_DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(ORDER_DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_sel;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`endif

// File: rtl/alu_result_merge.sv
// -----------------------------------------------------------------------------
// alu_result_merge
// Merges the two ALU result channels into one registered result stream for
// writeback. Channel 1 carries aluOpSel=1 results and channel 2 carries
// aluOpSel=0 results. The block arbitrates between them and holds the winner in a
// one-entry output stage.
//
// Handshake rule (all three interfaces): a beat transfers on a rising clk edge
// where valid & ready are both 1. Producers raise valid without waiting for ready.
// in1_ready and in2_ready depend on the valids and are never both 1 in a cycle.
// While out_valid & !out_ready, out_data and out_src hold stable.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in1_valid/ready/data : channel-1 results (aluOpSel = 1)
//   in2_valid/ready/data : channel-2 results (aluOpSel = 0)
//   out_valid/ready/data : merged result toward writeback
//   out_src              : source tag of out_data (1 = channel 1, 0 = channel 2)
// Optional (macro MERGE_INORDER_EN):
//   issue_valid/ready/sel : issue-order stream. Each push records the aluOpSel
//                           value of an issued op. A result is granted only when
//                           its channel matches the oldest record. Results
//                           therefore leave in issue order.
// Without the macro the block uses plain round robin between the channels.
// -----------------------------------------------------------------------------
module alu_result_merge
  import alu_merge_pkg::*;
#(
  parameter int BITS_SIZE   = 64,
  parameter int ORDER_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in1_valid,
  output logic                 in1_ready,
  input  logic [BITS_SIZE-1:0] in1_data,
  input  logic                 in2_valid,
  output logic                 in2_ready,
  input  logic [BITS_SIZE-1:0] in2_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITS_SIZE-1:0] out_data,
  output logic                 out_src
`ifdef MERGE_INORDER_EN
  ,
  input  logic                 issue_valid,
  input  logic                 issue_sel,
  output logic                 issue_ready
`endif
);

  if (ORDER_DEPTH < 1) begin : g_depth_check
    $error("ORDER_DEPTH must be at least 1");
  end

  // Arbiter state and output stage registers.
  grant_e               last_grant;
  grant_e               last_grant_nxt;
  logic                 out_valid_nxt;
  logic [BITS_SIZE-1:0] out_data_nxt;
  logic                 out_src_nxt;

  // Combinational arbitration.
  logic elig1;
  logic elig2;
  sel_e grant;
  logic can_load;
  logic accept;

`ifdef MERGE_INORDER_EN
  logic order_head;
  logic order_empty;
  logic order_full;

  assign issue_ready = ~order_full;

  merge_order_fifo #(
    .ORDER_DEPTH(ORDER_DEPTH)
  ) u_order_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (issue_valid & issue_ready),
    .push_sel (issue_sel),
    .pop      (accept),
    .head     (order_head),
    .empty    (order_empty),
    .full     (order_full)
  );
`endif

  always_comb begin
    elig1          = in1_valid;
    elig2          = in2_valid;
`ifdef MERGE_INORDER_EN
    // Only the channel named by the oldest issue record may compete. At most
    // one channel is eligible, so round robin never decides in this mode.
    elig1          = in1_valid & ~order_empty & (order_head == SRC_CH1);
    elig2          = in2_valid & ~order_empty & (order_head == SRC_CH2);
`endif
    grant          = SEL_NONE;
    if (elig1 && elig2) begin
      grant = (last_grant == GRANT_CH1) ? SEL_CH2 : SEL_CH1;
    end else if (elig1) begin
      grant = SEL_CH1;
    end else if (elig2) begin
      grant = SEL_CH2;
    end

    // The stage can take a new beat if it is empty or is being drained this cycle.
    can_load       = ~out_valid | out_ready;
    // rst_n is included so that no beat appears accepted while reset is held.
    in1_ready      = rst_n & can_load & (grant == SEL_CH1);
    in2_ready      = rst_n & can_load & (grant == SEL_CH2);
    accept         = in1_ready | in2_ready;

    last_grant_nxt = last_grant;
    out_valid_nxt  = out_valid;
    out_data_nxt   = out_data;
    out_src_nxt    = out_src;
    if (in1_ready) begin
      out_valid_nxt  = 1'b1;
      out_data_nxt   = in1_data;
      out_src_nxt    = SRC_CH1;
      last_grant_nxt = GRANT_CH1;
    end else if (in2_ready) begin
      out_valid_nxt  = 1'b1;
      out_data_nxt   = in2_data;
      out_src_nxt    = SRC_CH2;
      last_grant_nxt = GRANT_CH2;
    end else if (out_ready) begin
      out_valid_nxt  = 1'b0;
    end
  end

  // Reset sets last_grant to channel 2, so channel 1 wins the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_CH2;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= SRC_CH2;
    end else begin
      last_grant <= last_grant_nxt;
      out_valid  <= out_valid_nxt;
      out_data   <= out_data_nxt;
      out_src    <= out_src_nxt;
    end
  end

endmodule

// File: tb/tb_alu_result_merge.sv
// -----------------------------------------------------------------------------
// tb_alu_result_merge
// Directed scenarios are followed by a randomized phase. A behavioural model runs
// in the negedge process. It checks every output each cycle and predicts the state
// after the next rising edge. Accepted results are queued and matched at the
// output handshake.
// -----------------------------------------------------------------------------
module tb_alu_result_merge;

  localparam int W = 64;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in1_valid;
  logic         in1_ready;
  logic [W-1:0] in1_data;
  logic         in2_valid;
  logic         in2_ready;
  logic [W-1:0] in2_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_src;
`ifdef MERGE_INORDER_EN
  logic         issue_valid;
  logic         issue_sel;
  logic         issue_ready;
`endif

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  alu_result_merge #(
    .BITS_SIZE   (W),
    .ORDER_DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .in2_valid (in2_valid),
    .in2_ready (in2_ready),
    .in2_data  (in2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
`ifdef MERGE_INORDER_EN
    ,
    .issue_valid (issue_valid),
    .issue_sel   (issue_sel),
    .issue_ready (issue_ready)
`endif
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  bit           m_valid;
  logic [W-1:0] m_data;
  bit           m_src;
  bit           m_last_ch1;   // 1 when channel 1 won most recently
  bit           oq[$];        // issue-order records (inorder build only)
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    bit           e1, e2, canl, push_ok;
    int           g;
    logic [W-1:0] e;
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_src", out_src, 0);
      chk("rst_in1_ready", in1_ready, 0);
      chk("rst_in2_ready", in2_ready, 0);
      m_valid = 0; m_data = '0; m_src = 0; m_last_ch1 = 0;
      exp_q.delete();
      oq.delete();
    end else begin
      chk("out_valid", out_valid, m_valid);
      chk("out_data", out_data, m_data);
      chk("out_src", out_src, m_src);
      e1 = in1_valid;
      e2 = in2_valid;
      push_ok = 0;
`ifdef MERGE_INORDER_EN
      e1 = in1_valid && oq.size() > 0 && oq[0] == 1'b1;
      e2 = in2_valid && oq.size() > 0 && oq[0] == 1'b0;
      chk("issue_ready", issue_ready, oq.size() < D);
      push_ok = issue_valid && (oq.size() < D);
`endif
      if (e1 && e2) g = m_last_ch1 ? 2 : 1;
      else if (e1) g = 1;
      else if (e2) g = 2;
      else g = 0;
      canl = !m_valid || out_ready;
      chk("in1_ready", in1_ready, canl && g == 1);
      chk("in2_ready", in2_ready, canl && g == 2);
      if (m_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: got transfer expected none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", out_data, e);
        end
      end
      if (canl && g != 0) begin
        m_valid    = 1;
        m_data     = (g == 1) ? in1_data : in2_data;
        m_src      = (g == 1);
        m_last_ch1 = (g == 1);
        exp_q.push_back(m_data);
        if (oq.size() > 0) void'(oq.pop_front());
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (push_ok) begin
`ifdef MERGE_INORDER_EN
        oq.push_back(issue_sel);
`endif
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    bit src_q[$];
    rst_n = 0;
    in1_valid = 1; in1_data = 64'h1111;
    in2_valid = 0; in2_data = '0;
    out_ready = 0;
`ifdef MERGE_INORDER_EN
    issue_valid = 0; issue_sel = 0;
`endif
    repeat (2) @(negedge clk);
    chk("T1_valid", out_valid, 0);
    chk("T1_data", out_data, 0);
    chk("T1_in1_ready", in1_ready, 0);

`ifndef MERGE_INORDER_EN
    step(); rst_n = 1;
    step(); in1_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("T1_first_data", out_data, 64'h1111);
    chk("T1_first_src", out_src, 1);

    // T2: contention alternates; channel 1 won last, so channel 2 goes first.
    step();
    in1_valid = 1; in1_data = 64'hAAAA_0000_0000_0001;
    in2_valid = 1; in2_data = 64'hBBBB_0000_0000_0002;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("T2_valid", out_valid, 1);
      chk("T2_src", out_src, (k % 2 == 0) ? 0 : 1);
      chk("T2_data", out_data, (k % 2 == 0) ? 64'hBBBB_0000_0000_0002 : 64'hAAAA_0000_0000_0001);
    end

    // T3: backpressure holds data and src; both readies stay low.
    step(); in1_data = 64'h1234; in2_valid = 0;
    step(); out_ready = 0; in1_data = 64'h9999; in2_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("T3_hold_data", out_data, 64'h1234);
      chk("T3_hold_src", out_src, 1);
      chk("T3_in1_ready", in1_ready, 0);
      chk("T3_in2_ready", in2_ready, 0);
    end
    step(); out_ready = 1; in1_valid = 0; in2_data = 64'h55;
    step(); in2_data = 64'hFF;
    @(negedge clk);
    chk("T3_reload_data", out_data, 64'h55);
    chk("T3_reload_src", out_src, 0);

    // T4: single 0xFF beat -> out_valid high for exactly one cycle.
    step(); in2_valid = 0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) begin
        cnt++;
        chk("T4_data", out_data, 64'hFF);
      end
    end
    chk("T4_valid_cycles", cnt, 1);

    // T5: asynchronous reset while stalled.
    step(); in1_valid = 1; in1_data = 64'h77; out_ready = 0;
    step(); in1_valid = 0;
    @(posedge clk); #3;
    chk("T5_stalled", out_valid, 1);
    chk("T5_stalled_data", out_data, 64'h77);
    rst_n = 0;
    #1;
    chk("T5_async_valid", out_valid, 0);
    chk("T5_async_data", out_data, 0);
    step(); rst_n = 1;
`else
    // T6: issue order 0,0,1 with channel 1 valid first.
    step(); rst_n = 1; issue_valid = 1; issue_sel = 0; in1_data = 64'h1; out_ready = 1;
    @(negedge clk);
    chk("T6_empty_no_grant", in1_ready, 0);
    step(); issue_sel = 0;
    step(); issue_sel = 1; in2_valid = 1; in2_data = 64'h2;
    @(negedge clk);
    chk("T6_in1_blocked", in1_ready, 0);
    step(); issue_valid = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) src_q.push_back(out_src);
    end
    chk("T6_count", src_q.size(), 3);
    if (src_q.size() == 3) begin
      chk("T6_src0", src_q[0], 0);
      chk("T6_src1", src_q[1], 0);
      chk("T6_src2", src_q[2], 1);
    end
    step(); in1_valid = 0; in2_valid = 0; issue_valid = 1; issue_sel = 1;
    repeat (4) @(posedge clk);
    #1; issue_valid = 0;
    @(negedge clk);
    chk("T6_full", issue_ready, 0);
    step(); rst_n = 0;
    step(); rst_n = 1;
`endif

    // Randomized phase with occasional resets.
    repeat (1500) begin
      step();
      rst_n     = ($urandom_range(0, 199) != 0);
      in1_valid = ($urandom_range(0, 3) != 0);
      in2_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in1_data  = {$urandom, $urandom};
      in2_data  = {$urandom, $urandom};
`ifdef MERGE_INORDER_EN
      issue_valid = $urandom_range(0, 1);
      issue_sel   = $urandom_range(0, 1);
`endif
    end
    step(); rst_n = 1;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
